// File: rtl/exu_arbiter.sv
// exu_arbiter: round-robin sharing of one combinational ALU (exu) between two requesters
// Ports: i_clk, i_rst (synchronous, active-high); i_reqN_* / o_reqN_ready carry op requests,
//        o_rspN_* / i_rspN_ready return results; o_alu_* drive the exu, i_alu_out is its result.
// Define EXU_ARB_FASTPATH_EN to feed the ALU straight from the granted request (no EXEC state).
module exu_arbiter #(
   parameter int DW  = 32,
   parameter int OPW = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_req0_valid,
   output logic           o_req0_ready,
   input  logic [OPW-1:0] i_req0_aluop,
   input  logic [DW-1:0]  i_req0_a,
   input  logic [DW-1:0]  i_req0_b,
   output logic           o_rsp0_valid,
   input  logic           i_rsp0_ready,
   output logic [DW-1:0]  o_rsp0_data,
   input  logic           i_req1_valid,
   output logic           o_req1_ready,
   input  logic [OPW-1:0] i_req1_aluop,
   input  logic [DW-1:0]  i_req1_a,
   input  logic [DW-1:0]  i_req1_b,
   output logic           o_rsp1_valid,
   input  logic           i_rsp1_ready,
   output logic [DW-1:0]  o_rsp1_data,
   output logic [OPW-1:0] o_alu_op,
   output logic [DW-1:0]  o_alu_a,
   output logic [DW-1:0]  o_alu_b,
   input  logic [DW-1:0]  i_alu_out
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_n;
   logic rr_last, owner, g0, g1, hs, rsp_take;
   logic [DW-1:0] result;
   // on a tie the requester that was not granted last wins; rr_last resets to 1 so requester 0 goes first
   assign g0 = i_req0_valid & (~i_req1_valid | rr_last);
   assign g1 = i_req1_valid & (~i_req0_valid | ~rr_last);
   assign o_req0_ready = (state == IDLE) & ~i_rst & g0;
   assign o_req1_ready = (state == IDLE) & ~i_rst & g1;
   assign hs = o_req0_ready | o_req1_ready;
   assign rsp_take = owner ? i_rsp1_ready : i_rsp0_ready;
   assign o_rsp0_valid = (state == RESP) & ~owner;
   assign o_rsp1_valid = (state == RESP) & owner;
   assign o_rsp0_data = o_rsp0_valid ? result : '0;
   assign o_rsp1_data = o_rsp1_valid ? result : '0;
`ifdef EXU_ARB_FASTPATH_EN
   localparam state_t HS_NEXT = RESP;
   assign o_alu_op = hs ? (g1 ? i_req1_aluop : i_req0_aluop) : '0;
   assign o_alu_a  = hs ? (g1 ? i_req1_a : i_req0_a) : '0;
   assign o_alu_b  = hs ? (g1 ? i_req1_b : i_req0_b) : '0;
`else
   localparam state_t HS_NEXT = EXEC;
   logic [OPW-1:0] op_q;
   logic [DW-1:0] a_q, b_q;
   assign o_alu_op = (state == EXEC) ? op_q : '0;
   assign o_alu_a  = (state == EXEC) ? a_q : '0;
   assign o_alu_b  = (state == EXEC) ? b_q : '0;
`endif
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    state_n = hs ? HS_NEXT : IDLE;
         EXEC:    state_n = RESP;
         RESP:    state_n = rsp_take ? IDLE : RESP;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         rr_last <= 1'b1;
         owner   <= 1'b0;
         result  <= '0;
`ifndef EXU_ARB_FASTPATH_EN
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
`endif
      end else begin
         state <= state_n;
         if (hs) begin
            owner   <= g1;
            rr_last <= g1;
         end
`ifdef EXU_ARB_FASTPATH_EN
         if (hs) result <= i_alu_out;
`else
         if (hs) begin
            op_q <= g1 ? i_req1_aluop : i_req0_aluop;
            a_q  <= g1 ? i_req1_a : i_req0_a;
            b_q  <= g1 ? i_req1_b : i_req0_b;
         end
         if (state == EXEC) result <= i_alu_out;
`endif
      end
   end
endmodule

// File: doc/exu_arbiter.md
Name: exu_arbiter

Overview:
- Shares the single combinational ALU (exu) between two requesters, for example the main issue path and a secondary address/CSR path.
- Accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures the result, and returns it over a per-requester response handshake.
- Round-robin arbitration gives fairness. The ALU module itself is unchanged and instantiated beside this block.

Parameters:
- DW, 32, operand/result width
- OPW, 4, ALU opcode width (0001 add, 0010 sub, 0011 xor, 0100 or, 0101 and, 0110 srl, 0111 sll, 1000 sra, others yield 0)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_req0_valid  in  1  requester 0 has an op
- o_req0_ready  out  1  requester 0 op accepted this cycle
- i_req0_aluop  in  OPW  requester 0 opcode
- i_req0_a  in  DW  requester 0 operand A
- i_req0_b  in  DW  requester 0 operand B
- o_rsp0_valid  out  1  result for requester 0 valid
- i_rsp0_ready  in  1  requester 0 takes result
- o_rsp0_data  out  DW  result for requester 0
- i_req1_*, o_req1_ready, o_rsp1_*, i_rsp1_ready  same as requester 0, for requester 1
- o_alu_op  out  OPW  to exu i_idu_aluop
- o_alu_a  out  DW  to exu i_idu_rs1_data
- o_alu_b  out  DW  to exu i_idu_rs2_data
- i_alu_out  in  DW  from exu o_exu_aluout

Behaviour:
- Clock is i_clk; reset is i_rst, synchronous and active-high, single clock domain.
- Reset values:
  - state=IDLE, rr_last=1 (so requester 0 has priority first)
  - op/a/b registers=0, owner=0, result=0
  - all o_rsp*_valid=0, o_rsp*_data=0, o_alu_op=0, o_alu_a=0, o_alu_b=0
  - o_req*_ready=0
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. If only one valid, that requester wins. If both valid, the requester != rr_last wins.
  - o_reqN_ready=1 only for the winner, and only in IDLE. Ready may depend on valid.
  - On a handshake: latch op/a/b, set owner=N and rr_last=N, go to EXEC.
  - No valid: stay in IDLE.
- EXEC (one cycle):
  - o_alu_op/a/b driven from the latched registers. In all other states they are 0.
  - result <= i_alu_out; go to RESP.
- RESP:
  - o_rsp{owner}_valid=1 and o_rsp{owner}_data=result. The other response valid stays 0.
  - Data is held stable until i_rsp{owner}_ready=1, then go to IDLE.
  - No new request is accepted in RESP.
- Latency: handshake in cycle T; response valid in cycle T+2. Peak throughput is one op per 3 cycles with immediate response ready.
- Fairness: with both requesters continuously valid and responses always ready, grants strictly alternate 0,1,0,1.
- A requester dropping valid before being granted is legal; no state change results.
- Undefined opcodes are passed through; the result is whatever the ALU returns (0).
- Arithmetic is fully in the ALU; the arbiter does no width change and no sign handling.
- Reset asserted in any state aborts the pending op:
  - no response is produced
  - the next cycle shows all valids/readies at 0 and state=IDLE.

Optional Feature:
- EXU_ARB_FASTPATH_EN defined:
  - EXEC is removed.
  - In IDLE the ALU inputs are driven combinationally from the granted requester's inputs.
  - result <= i_alu_out on the handshake cycle, and the FSM goes straight to RESP.
  - Latency is T+1; peak throughput is one op per 2 cycles.
  - Outside IDLE the ALU inputs are 0.
- Not defined: the three-state behaviour above, with latency T+2. ALU inputs are then driven only from registers, which gives a timing-clean path.

Test Plan:
- Single op: req0 add a=5, b=3 handshake at T -> o_rsp0_valid=1 at T+2, data=0x00000008; o_rsp1_valid stays 0.
- Both requesters valid at T after reset: req0 sub a=3, b=5; req1 xor a=0xFF00FF00, b=0x0F0F0F0F. Expected: req0 granted first with rsp0=0xFFFFFFFE; then req1 granted with rsp1=0xF00FF00F.
- Continuous contention over 6 ops with rsp ready always 1 -> grant order 0,1,0,1,0,1; each o_req_ready pulse is 3 cycles apart (2 cycles with EXU_ARB_FASTPATH_EN).
- Backpressure: i_rsp1_ready=0 for 5 cycles during RESP with or a=0x1, b=0x2 -> o_rsp1_valid=1 and data=0x00000003 stable for all 5 cycles; o_req*_ready stays 0 until the cycle after ready rises.
- Undefined opcode 4'b1111 from req1 -> o_rsp1_data=0x00000000, with the normal handshake.
- Reset mid-op: i_rst=1 in the EXEC or RESP cycle -> next cycle all outputs 0, and no response is delivered after reset release. The next op after release goes to req0 first.
